scs8hd_clkdiv_gen: RTL and testbench
====================================

Name: scs8hd_clkdiv_gen

Overview:
- Synchronous, glitch-free programmable clock divider. Generates the divided clock that feeds a downstream clock buffer tree.
- Divide ratio is changed at run time through a valid/ready handshake. A new ratio is applied only at a period boundary, so X never produces a runt pulse.
- Sits at the clock-source end of a buffered distribution, in the CLK domain, ahead of the clkbuf/clkinv cells.

Parameters:
- DIVW, 4, width of the divide-ratio field.
- RST_DIV, 2, ratio loaded at reset. Must be >= 2 and < 2^DIVW.

Ports:
- CLK  input  1  source clock; all state updates on its rising edge.
- RESETB  input  1  synchronous, active-low reset.
- DIV  input  DIVW  requested divide ratio N.
- DIV_VALID  input  1  DIV is valid this cycle.
- DIV_READY  output  1  block can accept a new ratio.
- X  output  1  divided clock, direct register output.
- TICK  output  1  one-cycle pulse in the first cycle of each X period, register output.
- ACTIVE_DIV  output  DIVW  ratio currently in effect.

Behaviour:
- Interface: one clock, CLK. Reset RESETB is synchronous and active-low.
- Reset (RESETB low at a CLK edge):
  - state = IDLE, cnt = 0, ACTIVE_DIV = RST_DIV, pending ratio cleared.
  - X = 0, TICK = 0, DIV_READY = 0.
  - Reset mid-period or mid-change aborts everything. Any pending ratio is discarded.
- States: IDLE, RUN, PEND.
  - IDLE -> RUN on the first edge with RESETB high. That edge starts period 0 with cnt = 0.
  - RUN -> PEND on an accepted handshake (DIV_VALID & DIV_READY).
  - PEND -> RUN at the period boundary that applies the pending ratio.
- Period counter cnt (DIVW bits):
  - Counts 0..N-1, with N = ACTIVE_DIV.
  - Wraps N-1 -> 0 at the period boundary.
- X timing, with H = N>>1:
  - X is 1 during cycles with cnt < H and 0 otherwise.
  - N=2: 1,0. N=3: 1,0,0. N=5: 1,1,0,0,0.
  - X and TICK are registered from next-state cnt. They carry no combinational path from any input.
- TICK = 1 exactly in cycles where cnt == 0 and state != IDLE.
- DIV_READY = 1 only in RUN. It drops to 0 the cycle after acceptance.
- Ratio capture and clamping:
  - On acceptance, DIV is captured as the pending ratio.
  - Values 0 and 1 are clamped to 2. No bypass mode exists.
- Applying a pending ratio:
  - Applied at the next wrap: ACTIVE_DIV updates in the same cycle cnt returns to 0.
  - The new period begins with the new ratio. State returns to RUN and DIV_READY returns to 1 in that cycle.
- Acceptance in the cycle where cnt == N-1: the change applies at the immediately following edge.
- DIV_VALID while DIV_READY = 0: ignored. No error flag, no queueing.
- DIV equal to ACTIVE_DIV: still a full handshake. It occupies PEND until the next boundary.
- X is never high or low for fewer cycles than the old or new ratio dictates.

Optional Feature:
- Macro: SCS8HD_CLKDIV_GATE_EN.
- When defined:
  - Adds input port GATE (1 bit), listed after DIV_VALID. Active high = run.
  - Adds state STOP.
  - GATE sampled low in RUN/PEND: the current period completes. At the boundary the block enters STOP instead of restarting. A pending ratio is still applied at that boundary.
  - In STOP: X = 0, TICK = 0, cnt held 0, DIV_READY = 1. A ratio accepted in STOP is applied immediately; DIV_READY = 0 for the next cycle only.
  - GATE sampled high in STOP: the next edge starts a period with cnt = 0, X = 1 (for H ≥ 1), TICK = 1.
- When not defined: no GATE port. Behaviour is identical to GATE tied high; STOP is unreachable.

Test Plan:
- Reset/default:
  - Stimulus: RESETB low 3 cycles, then high, RST_DIV = 2.
  - Response: X/TICK/DIV_READY = 0 during reset. Afterwards X = 1,0,1,0..., TICK = 1 on every X-high cycle, ACTIVE_DIV = 2.
- Ratio change mid-period:
  - Stimulus: while N = 4, accept DIV = 5 at cnt = 1.
  - Response: DIV_READY = 0 next cycle. Current period finishes as 1,1,0,0. Next period is 1,1,0,0,0 with ACTIVE_DIV = 5, and DIV_READY = 1 at that TICK.
- Boundary acceptance:
  - Stimulus: with N = 3, accept DIV = 6 at cnt = 2.
  - Response: the very next cycle has cnt = 0, ACTIVE_DIV = 6, TICK = 1, and X pattern 1,1,1,0,0,0.
- Clamp and ignore:
  - Stimulus: accept DIV = 1. During PEND, drive DIV_VALID with DIV = 9.
  - Response: ACTIVE_DIV becomes 2. DIV = 9 is ignored and ACTIVE_DIV never becomes 9.
- Reset mid-change:
  - Stimulus: accept DIV = 7, then assert RESETB low before the boundary.
  - Response: ACTIVE_DIV = RST_DIV after reset. The 7 is never applied.
- Gate (SCS8HD_CLKDIV_GATE_EN):
  - Stimulus: N = 4, drop GATE at cnt = 1, raise it 5 cycles later.
  - Response: the period completes, then X = 0 and TICK = 0 while stopped. Restart gives X = 1,1,0,0 with TICK on the first cycle.

Source files
------------

// File: rtl/scs8hd_clkdiv_gen.sv
// scs8hd_clkdiv_gen: glitch-free programmable clock divider with a
// valid/ready ratio-change handshake applied only at period boundaries.
//
// Ports:
//   CLK        source clock (rising edge)
//   RESETB     synchronous active-low reset
//   DIV        requested divide ratio N (0/1 clamp to 2)
//   DIV_VALID  DIV is valid this cycle
//   GATE       run enable (only with SCS8HD_CLKDIV_GATE_EN)
//   DIV_READY  block can accept a new ratio
//   X          divided clock, register output
//   TICK       pulse in first cycle of each X period, register output
//   ACTIVE_DIV ratio currently in effect
//
// Optional feature macro: SCS8HD_CLKDIV_GATE_EN adds GATE and a STOP state.
module scs8hd_clkdiv_gen #(
  parameter int DIVW    = 4,
  parameter int RST_DIV = 2
) (
  input  logic            CLK,
  input  logic            RESETB,
  input  logic [DIVW-1:0] DIV,
  input  logic            DIV_VALID,
`ifdef SCS8HD_CLKDIV_GATE_EN
  input  logic            GATE,
`endif
  output logic            DIV_READY,
  output logic            X,
  output logic            TICK,
  output logic [DIVW-1:0] ACTIVE_DIV
);

`ifdef SCS8HD_CLKDIV_GATE_EN
  typedef enum logic [1:0] {
    IDLE, RUN, PEND, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, RUN, PEND
  } state_t;
`endif

  localparam logic [DIVW-1:0] RST_N = DIVW'(RST_DIV);
  localparam logic [DIVW-1:0] MIN_N = DIVW'(2);

  state_t          state, state_n;
  logic [DIVW-1:0] cnt, cnt_n;
  logic [DIVW-1:0] act, act_n;
  logic [DIVW-1:0] pend, pend_n;
  logic            x_q, x_n;
  logic            tick_q, tick_n;

  logic            accept;
  logic            last;
  logic [DIVW-1:0] div_cl;
  logic [DIVW-1:0] h_n;
  logic            run_n;

`ifdef SCS8HD_CLKDIV_GATE_EN
  logic stop_req, stop_req_n;
  logic hold_q, hold_n;
`endif

  // Ratios 0 and 1 have no meaningful X waveform; force them to 2.
  assign div_cl = (DIV < MIN_N) ? MIN_N : DIV;
  assign last   = (cnt == act - DIVW'(1));

`ifdef SCS8HD_CLKDIV_GATE_EN
  assign DIV_READY = (state == RUN) |
                     ((state == STOP) & ~hold_q);
`else
  assign DIV_READY = (state == RUN);
`endif

  assign accept = DIV_VALID & DIV_READY;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    act_n   = act;
    pend_n  = pend;
`ifdef SCS8HD_CLKDIV_GATE_EN
    stop_req_n = stop_req;
    hold_n     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        state_n = RUN;
        cnt_n   = '0;
      end
      RUN, PEND: begin
        if (accept) begin
          pend_n  = div_cl;
          state_n = PEND;
        end
`ifdef SCS8HD_CLKDIV_GATE_EN
        if (!GATE) stop_req_n = 1'b1;
`endif
        if (last) begin
          cnt_n = '0;
          // A ratio accepted on the last cycle takes effect right away.
          if (state == PEND) act_n = pend;
          else if (accept)   act_n = div_cl;
          state_n = RUN;
`ifdef SCS8HD_CLKDIV_GATE_EN
          if (stop_req || !GATE) state_n = STOP;
          stop_req_n = 1'b0;
`endif
        end else begin
          cnt_n = cnt + DIVW'(1);
        end
      end
`ifdef SCS8HD_CLKDIV_GATE_EN
      STOP: begin
        cnt_n = '0;
        if (accept) begin
          act_n  = div_cl;
          hold_n = 1'b1;
        end
        if (GATE) state_n = RUN;
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs come from next-state values so they stay pure flops.
  assign h_n    = act_n >> 1;
  assign run_n  = (state_n == RUN) | (state_n == PEND);
  assign x_n    = run_n & (cnt_n < h_n);
  assign tick_n = run_n & (cnt_n == '0);

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state  <= IDLE;
      cnt    <= '0;
      act    <= RST_N;
      pend   <= '0;
      x_q    <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      act    <= act_n;
      pend   <= pend_n;
      x_q    <= x_n;
      tick_q <= tick_n;
    end
  end

`ifdef SCS8HD_CLKDIV_GATE_EN
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      stop_req <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      stop_req <= stop_req_n;
      hold_q   <= hold_n;
    end
  end
`endif

  assign X          = x_q;
  assign TICK       = tick_q;
  assign ACTIVE_DIV = act;

endmodule

// File: tb/tb_scs8hd_clkdiv_gen.sv
// tb_scs8hd_clkdiv_gen: directed and random checks of the clock divider
// against a period/position reference model.
module tb_scs8hd_clkdiv_gen;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [3:0] div = '0;
  logic       div_valid = 1'b0;
  logic       div_ready;
  logic       x;
  logic       tick;
  logic [3:0] active_div;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: started flag, position in period, ratio, pending
  bit m_run  = 0;
  int m_pos  = 0;
  int m_n    = 2;
  bit m_pend = 0;
  int m_pv   = 0;
  bit seen9  = 0;

  always #5 clk = ~clk;

  scs8hd_clkdiv_gen #(.DIVW(4), .RST_DIV(2)) dut (
    .CLK(clk),
    .RESETB(rstb),
    .DIV(div),
    .DIV_VALID(div_valid),
`ifdef SCS8HD_CLKDIV_GATE_EN
    .GATE(1'b1),
`endif
    .DIV_READY(div_ready),
    .X(x),
    .TICK(tick),
    .ACTIVE_DIV(active_div)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_run && !m_pend;
  endfunction

  task automatic model_step(input bit r, input bit v, input int d);
    bit acc;
    if (!r) begin
      m_run = 0; m_pos = 0; m_n = 2; m_pend = 0;
      return;
    end
    if (!m_run) begin
      m_run = 1; m_pos = 0;
      return;
    end
    acc = v && m_ready();
    if (acc) begin
      m_pend = 1;
      m_pv = (d < 2) ? 2 : d;
    end
    if (m_pos == m_n - 1) begin
      m_pos = 0;
      if (m_pend) begin
        m_n = m_pv;
        m_pend = 0;
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic cyc(input bit r, input bit v, input int d);
    @(negedge clk);
    rstb = r; div_valid = v; div = 4'(d);
    @(posedge clk);
    model_step(r, v, d);
    #1;
    chk("x", int'(x), int'(m_run && (m_pos < (m_n >> 1))));
    chk("tick", int'(tick), int'(m_run && m_pos == 0));
    chk("ready", int'(div_ready), int'(m_ready()));
    chk("active", int'(active_div), m_n);
    if (active_div == 4'd9) seen9 = 1;
  endtask

  task automatic set_n(input int val);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (m_ready()) begin
        cyc(1, 1, val);
        done = 1;
      end else begin
        cyc(1, 0, 0);
      end
    end
    for (int i = 0; i < 40 && m_pend; i++) cyc(1, 0, 0);
    if (!done || m_pend) chk("set_n_timeout", 1, 0);
  endtask

  task automatic wait_pos(input int p);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_pos == p && m_ready()) ok = 1;
      else cyc(1, 0, 0);
    end
    if (!ok) chk("wait_pos_timeout", 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);

    // mid-period change 4 -> 5
    set_n(4);
    wait_pos(1);
    cyc(1, 1, 5);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0);
    chk("n_after_mid", int'(active_div), 5);

    // boundary acceptance 3 -> 6
    set_n(3);
    wait_pos(2);
    cyc(1, 1, 6);
    chk("bnd_active", int'(active_div), 6);
    chk("bnd_tick", int'(tick), 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0);

    // clamp 1 -> 2, ignore 9 while pending
    wait_pos(0);
    cyc(1, 1, 1);
    for (int i = 0; i < 40 && m_pend; i++) cyc(1, 1, 9);
    cyc(1, 0, 0);
    chk("clamp", int'(active_div), 2);
    chk("no9", int'(seen9), 0);

    // reset mid-change
    set_n(5);
    wait_pos(0);
    cyc(1, 1, 7);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("rst_active", int'(active_div), 2);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) != 0),
          ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
